// File: rtl/mult8_tdm_ctrl_if.sv
// Operand request and result hand-off bus for mult8_tdm_ctrl.
// The master side requests operands and consumes results; the slave side is the controller.
interface mult8_tdm_ctrl_if;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        approx;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] r;

    modport master (
        output in_valid, a, b, approx, out_ready,
        input  in_ready, out_valid, r
    );

    modport slave (
        input  in_valid, a, b, approx, out_ready,
        output in_ready, out_valid, r
    );
endinterface

// File: rtl/mult8_tdm_ctrl.sv
// Time-multiplexed 8x8 unsigned multiplier: steps one shared 4x4 unit through the nibble
// products, shift-accumulates them, and returns the 16-bit result over valid/ready.
module mult8_tdm_ctrl #(
    parameter int unsigned CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    mult8_tdm_ctrl_if.slave   bus,
    output logic [3:0]        pp_x,
    output logic [3:0]        pp_y,
    input  logic [7:0]        pp_p,
    output logic              busy,
    output logic [CNT_W-1:0]  ops_done
);

    typedef enum logic [2:0] {StIdle, StLl, StHl, StLh, StHh, StDone} state_e;

    state_e           state_q, state_d;
    logic [7:0]       a_q, b_q;
    logic [15:0]      acc_q, acc_sum, addend;
    logic [15:0]      r_q;
    logic [CNT_W-1:0] ops_q;
    logic             accept, handoff;

    assign accept  = (state_q == StIdle) && bus.in_valid;
    assign handoff = (state_q == StDone) && bus.out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (bus.in_valid) state_d = bus.approx ? StHl : StLl;
            StLl:   state_d = StHl;
            StHl:   state_d = StLh;
            StLh:   state_d = StHh;
            StHh:   state_d = StDone;
            StDone: if (bus.out_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Operands stay at zero outside the product states so the shared unit sees no toggling.
    always_comb begin
        pp_x   = 4'h0;
        pp_y   = 4'h0;
        addend = 16'h0;
        unique case (state_q)
            StLl: begin
                pp_x   = a_q[3:0];
                pp_y   = b_q[3:0];
                addend = {8'h00, pp_p};
            end
            StHl: begin
                pp_x   = a_q[7:4];
                pp_y   = b_q[3:0];
                addend = {4'h0, pp_p, 4'h0};
            end
            StLh: begin
                pp_x   = a_q[3:0];
                pp_y   = b_q[7:4];
                addend = {4'h0, pp_p, 4'h0};
            end
            StHh: begin
                pp_x   = a_q[7:4];
                pp_y   = b_q[7:4];
                addend = {pp_p, 8'h00};
            end
            default: ;
        endcase
    end

    assign acc_sum = acc_q + addend;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q   <= 8'h00;
            b_q   <= 8'h00;
            acc_q <= 16'h0000;
            r_q   <= 16'h0000;
            ops_q <= '0;
        end else begin
            if (accept) begin
                a_q   <= bus.a;
                b_q   <= bus.b;
                acc_q <= 16'h0000;
            end else if (state_q != StIdle && state_q != StDone) begin
                acc_q <= acc_sum;
            end
            if (state_q == StHh) begin
                r_q <= acc_sum;
            end
            if (handoff && ops_q != {CNT_W{1'b1}}) begin
                ops_q <= ops_q + 1'b1;
            end
        end
    end

    assign bus.in_ready  = (state_q == StIdle);
    assign bus.out_valid = (state_q == StDone);
    assign bus.r         = r_q;
    assign busy          = (state_q != StIdle);
    assign ops_done      = ops_q;

endmodule

// File: tb/tb_mult8_tdm_ctrl.sv
// Self-checking bench for mult8_tdm_ctrl against an arithmetic reference model.
module tb_mult8_tdm_ctrl;
    localparam int CNT_W = 2;
    localparam int MAX_LAT = 20;

    logic             clk;
    logic             rst_n;
    logic [3:0]       pp_x, pp_y;
    logic [7:0]       pp_p;
    logic             busy;
    logic [CNT_W-1:0] ops_done;

    mult8_tdm_ctrl_if bus ();

    mult8_tdm_ctrl #(.CNT_W(CNT_W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .pp_x     (pp_x),
        .pp_y     (pp_y),
        .pp_p     (pp_p),
        .busy     (busy),
        .ops_done (ops_done)
    );

    // Behavioural stand-in for the shared 4x4 unit.
    assign pp_p = {4'h0, pp_x} * {4'h0, pp_y};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int exp_cnt  = 0;
    logic [7:0] pp_seq[$];

    function automatic int ref_prod(input int a, input int b, input bit ap);
        int p;
        p = a * b;
        if (ap) p = p - (a % 16) * (b % 16);
        return p;
    endfunction

    function automatic int sat_inc(input int c);
        return (c == (1 << CNT_W) - 1) ? c : c + 1;
    endfunction

    // Issue one request, then scramble the inputs and wait for out_valid.
    task automatic do_op(input logic [7:0] ia, input logic [7:0] ib, input logic iap,
                         output int lat);
        bus.a = ia; bus.b = ib; bus.approx = iap; bus.in_valid = 1'b1; bus.out_ready = 1'b0;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.a = 8'($urandom); bus.b = 8'($urandom); bus.approx = 1'($urandom);
        pp_seq.delete();
        lat = 0;
        while (!bus.out_valid && lat < MAX_LAT) begin
            if (pp_x != 4'h0 || pp_y != 4'h0) pp_seq.push_back({pp_x, pp_y});
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic finish_op();
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        exp_cnt = sat_inc(exp_cnt);
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        bus.a = 8'h00; bus.b = 8'h00; bus.approx = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        exp_cnt = 0;
    endtask

    task automatic test_reset();
        apply_reset();
        n_checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || busy !== 1'b0) begin
            $display("FAIL reset_ctrl: in_ready=%b out_valid=%b busy=%b, required 1 0 0",
                     bus.in_ready, bus.out_valid, busy);
        end else n_pass++;
        n_checks++;
        if (bus.r !== 16'h0 || pp_x !== 4'h0 || pp_y !== 4'h0 || ops_done !== '0) begin
            $display("FAIL reset_data: r=%h pp=%h,%h ops=%0d, required all zero",
                     bus.r, pp_x, pp_y, ops_done);
        end else n_pass++;
    endtask

    task automatic test_exact_max();
        int lat;
        do_op(8'hFF, 8'hFF, 1'b0, lat);
        n_checks++;
        if (lat !== 4 || bus.r !== 16'(ref_prod(255, 255, 1'b0))) begin
            $display("FAIL exact_max: lat=%0d r=%h, required lat=4 r=%h",
                     lat, bus.r, 16'(ref_prod(255, 255, 1'b0)));
        end else n_pass++;
        n_checks++;
        if (pp_seq.size() != 4 || pp_seq[0] !== 8'hFF || pp_seq[3] !== 8'hFF) begin
            $display("FAIL exact_max_pp: %0d nonzero pp cycles, required 4 of FF",
                     pp_seq.size());
        end else n_pass++;
        n_checks++;
        if (bus.in_ready !== 1'b0 || busy !== 1'b1) begin
            $display("FAIL exact_max_done: in_ready=%b busy=%b, required 0 1",
                     bus.in_ready, busy);
        end else n_pass++;
        finish_op();
        n_checks++;
        if (ops_done !== CNT_W'(exp_cnt) || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            $display("FAIL exact_max_handoff: ops=%0d out_valid=%b in_ready=%b, required %0d 0 1",
                     ops_done, bus.out_valid, bus.in_ready, exp_cnt);
        end else n_pass++;
    endtask

    task automatic test_approx_max();
        int lat;
        do_op(8'hFF, 8'hFF, 1'b1, lat);
        n_checks++;
        if (lat !== 3 || bus.r !== 16'(ref_prod(255, 255, 1'b1)) || pp_seq.size() != 3) begin
            $display("FAIL approx_max: lat=%0d r=%h pp_cycles=%0d, required 3 %h 3",
                     lat, bus.r, pp_seq.size(), 16'(ref_prod(255, 255, 1'b1)));
        end else n_pass++;
        finish_op();
    endtask

    task automatic test_small();
        int lat;
        logic [7:0] exp_seq[4];
        exp_seq = '{8'h24, 8'h14, 8'h23, 8'h13};
        for (int m = 0; m < 2; m++) begin
            do_op(8'h12, 8'h34, 1'(m), lat);
            n_checks++;
            if (lat !== 4 - m || bus.r !== 16'(ref_prod('h12, 'h34, 1'(m)))) begin
                $display("FAIL small_m%0d: lat=%0d r=%h, required %0d %h",
                         m, lat, bus.r, 4 - m, 16'(ref_prod('h12, 'h34, 1'(m))));
            end else n_pass++;
            n_checks++;
            if (pp_seq.size() != 4 - m || pp_seq[0] !== exp_seq[m]) begin
                $display("FAIL small_pp_m%0d: first pp=%h cycles=%0d, required %h %0d",
                         m, pp_seq[0], pp_seq.size(), exp_seq[m], 4 - m);
            end else n_pass++;
            finish_op();
        end
    endtask

    task automatic test_backpressure();
        int lat;
        int bad;
        logic [15:0] held;
        do_op(8'h9C, 8'h47, 1'b0, lat);
        held = 16'(ref_prod('h9C, 'h47, 1'b0));
        bad = 0;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            bus.a = 8'($urandom); bus.b = 8'($urandom);
            @(posedge clk); #1;
            if (bus.r !== held || bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) bad++;
        end
        n_checks++;
        if (bad != 0) begin
            $display("FAIL backpressure_hold: %0d bad cycles, last r=%h, required 0 with r=%h",
                     bad, bus.r, held);
        end else n_pass++;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b0;
        exp_cnt = sat_inc(exp_cnt);
        n_checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || ops_done !== CNT_W'(exp_cnt)) begin
            $display("FAIL backpressure_release: out_valid=%b in_ready=%b ops=%0d, required 0 1 %0d",
                     bus.out_valid, bus.in_ready, ops_done, exp_cnt);
        end else n_pass++;
    endtask

    task automatic test_random();
        int lat;
        int bad;
        logic [7:0] ra, rb;
        logic       rap;
        bad = 0;
        for (int i = 0; i < 24; i++) begin
            ra = 8'($urandom); rb = 8'($urandom); rap = 1'($urandom);
            do_op(ra, rb, rap, lat);
            if (lat != (rap ? 3 : 4) || bus.r !== 16'(ref_prod(ra, rb, rap))) begin
                bad++;
                $display("FAIL random_op: a=%h b=%h approx=%b r=%h lat=%0d, required %h",
                         ra, rb, rap, bus.r, lat, 16'(ref_prod(ra, rb, rap)));
            end
            finish_op();
        end
        n_checks++;
        if (bad == 0) n_pass++;
    endtask

    task automatic test_reset_midop();
        int lat;
        bus.a = 8'h5B; bus.b = 8'hC3; bus.approx = 1'b0; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        n_checks++;
        if (pp_x !== 4'hB || pp_y !== 4'hC) begin
            $display("FAIL midop_lh: pp=%h,%h, required b,c", pp_x, pp_y);
        end else n_pass++;
        rst_n = 1'b0;
        #1;
        exp_cnt = 0;
        n_checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.r !== 16'h0 || busy !== 1'b0
            || pp_x !== 4'h0 || pp_y !== 4'h0 || ops_done !== '0) begin
            $display("FAIL midop_reset: in_ready=%b out_valid=%b r=%h busy=%b pp=%h,%h ops=%0d",
                     bus.in_ready, bus.out_valid, bus.r, busy, pp_x, pp_y, ops_done);
        end else n_pass++;
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        do_op(8'h0A, 8'h0B, 1'b0, lat);
        n_checks++;
        if (lat !== 4 || bus.r !== 16'(ref_prod('h0A, 'h0B, 1'b0))) begin
            $display("FAIL midop_after: lat=%0d r=%h, required 4 %h",
                     lat, bus.r, 16'(ref_prod('h0A, 'h0B, 1'b0)));
        end else n_pass++;
        finish_op();
    endtask

    task automatic test_saturation();
        int lat;
        apply_reset();
        for (int i = 0; i < 5; i++) begin
            do_op(8'($urandom), 8'($urandom), 1'($urandom), lat);
            finish_op();
            n_checks++;
            if (ops_done !== CNT_W'(exp_cnt)) begin
                $display("FAIL saturation_%0d: ops_done=%0d, required %0d", i, ops_done, exp_cnt);
            end else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_exact_max();
        test_approx_max();
        test_small();
        test_backpressure();
        test_random();
        test_reset_midop();
        test_saturation();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
